muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have in_valid  input  1  request present.
REQ-005 SHALL have in_ready  output  1  unit can accept a request.
REQ-006 SHALL have in_op  input  2  operation: 0 MUL (low half), 1 MULHU (high half, unsigned), 2 DIVU, 3 REMU.
REQ-007 SHALL have in_a  input  DATA_WIDTH  operand A, from register-file result_1.
REQ-008 SHALL have in_b  input  DATA_WIDTH  operand B, from register-file result_2.
REQ-009 SHALL have in_rd  input  5  destination register index.
REQ-010 SHALL have out_valid  output  1  result present.
REQ-011 SHALL have out_ready  input  1  writeback consumer accepts the result.
REQ-012 SHALL have out_rd  output  5  destination index, driven to the register-file write_register.
REQ-013 SHALL have out_data  output  DATA_WIDTH  result, driven to the register-file write_data.
REQ-014 SHALL have busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, CALC and DONE; in_ready SHALL be high only in IDLE.
REQ-016 SHALL accept a request on a rising edge with in_valid && in_ready, latch in_op, in_a, in_b and in_rd, and move to CALC.
- Input changes after the accepting edge SHALL be ignored.
REQ-017 SHALL remain in CALC for exactly DATA_WIDTH rising edges, processing one bit per edge, then move to DONE.
- MUL and MULHU: shift-add into a 2*DATA_WIDTH-bit product.
- DIVU and REMU: restoring division with a DATA_WIDTH-bit quotient and remainder.
REQ-018 SHALL drive out_valid high in DONE only; out_valid SHALL first be high after DATA_WIDTH+1 edges counted from and including the accepting edge.
REQ-019 SHALL select out_data as follows: MUL = product[DATA_WIDTH-1:0]; MULHU = product[2*DATA_WIDTH-1:DATA_WIDTH]; DIVU = quotient; REMU = remainder.
REQ-020 SHALL, in DONE with out_ready low, hold out_valid, out_rd and out_data stable indefinitely.
REQ-021 SHALL, in DONE with out_ready high, complete the transfer on that edge and return to IDLE.
- A new request SHALL be accepted no earlier than the following edge; there is no back-to-back overlap.
REQ-022 SHALL, when in_b == 0, produce DIVU = all ones and REMU = in_a, with the same latency as any other operation.
REQ-023 SHALL drive out_rd = 0 and out_data = 0 whenever out_valid is low, so that an idle unit issues a register-file no-op.
REQ-024 SHALL compute normally when in_rd == 0; discarding the result is left to the register file.
REQ-025 SHALL use an iteration counter of $clog2(DATA_WIDTH)+1 bits; the counter SHALL NOT wrap within an operation.

Reset
REQ-026 SHALL, on a rising edge with rst high, enter IDLE regardless of the current state, abandoning any operation in progress.
REQ-027 SHALL hold these values during and after reset: in_ready=1 (visible in the cycle after the reset edge), out_valid=0, out_rd=0, out_data=0, busy=0.
- The counter and all datapath registers SHALL be cleared to 0.
REQ-028 SHALL give rst priority over in_valid and out_ready on the same edge; no request is accepted and no result is transferred.

Structure
REQ-029 SHALL take muldiv_op_t (2-bit enum MUL, MULHU, DIVU, REMU) and REG_ADDR_WIDTH = 5 from the shared package cpu_pkg.
REQ-030 SHALL be a single module with no sub-modules; the multiply and divide paths SHALL share the FSM and counter.

Verification
REQ-031 SHALL cover MUL 7 x 6, rd=5: result 42 with out_rd=5, and out_valid first high 33 edges after the accepting edge.
REQ-032 SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF: result 0xFFFFFFFE; MUL of the same operands: result 0x00000001.
REQ-033 SHALL cover DIVU 100 / 7: result 14; REMU 100 / 7: result 2; REMU 0x80000000 / 1: result 0.
REQ-034 SHALL cover DIVU 9 / 0: result 0xFFFFFFFF; REMU 9 / 0: result 9.
REQ-035 SHALL cover out_ready held low for 10 cycles in DONE: out_valid, out_rd and out_data stable, in_ready low; then out_ready=1 gives one transfer and in_ready=1 on the next cycle.
REQ-036 SHALL cover rst asserted at CALC iteration 12: next cycle in IDLE with out_valid=0, busy=0, in_ready=1; a following MUL 3 x 3 returns 9.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register address width and multiply/divide opcodes.
// Opcode encodings match the in_op field driven by the issue stage.
package cpu_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    MULDIV_MUL   = 2'd0,
    MULDIV_MULHU = 2'd1,
    MULDIV_DIVU  = 2'd2,
    MULDIV_REMU  = 2'd3
  } muldiv_op_t;

  function automatic logic op_is_mul(input muldiv_op_t op);
    return (op == MULDIV_MUL) || (op == MULDIV_MULHU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one bit per clock, shared counter and accumulator.
// Results are presented in DONE and held until the writeback consumer accepts them.
//
// state | meaning
// IDLE  | waiting for a request; in_ready high
// CALC  | DATA_WIDTH shift-add or restoring-divide iterations
// DONE  | result valid, waiting for out_ready
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_op,
  input  logic [DATA_WIDTH-1:0]     in_a,
  input  logic [DATA_WIDTH-1:0]     in_b,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state, w_state_nxt;
  muldiv_op_t                r_op;
  logic [DATA_WIDTH-1:0]     r_b;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [CNT_W-1:0]          r_cnt;
  // hi/lo hold product halves for multiply, remainder/quotient for divide
  logic [DATA_WIDTH-1:0]     r_hi;
  logic [DATA_WIDTH-1:0]     r_lo;

  logic                      w_is_mul;
  logic [DATA_WIDTH:0]       w_sum;
  logic [DATA_WIDTH-1:0]     w_mul_hi, w_mul_lo;
  logic [DATA_WIDTH:0]       w_shift;
  logic                      w_ge;
  logic [DATA_WIDTH-1:0]     w_div_hi, w_div_lo;

  assign w_is_mul = op_is_mul(r_op);

  // Shift-add step: conditionally add B into the upper half, then shift the product right.
  always_comb begin
    w_sum = {1'b0, r_hi} + {1'b0, r_b};
    if (r_lo[0]) begin
      w_mul_hi = w_sum[DATA_WIDTH:1];
      w_mul_lo = {w_sum[0], r_lo[DATA_WIDTH-1:1]};
    end else begin
      w_mul_hi = {1'b0, r_hi[DATA_WIDTH-1:1]};
      w_mul_lo = {r_hi[0], r_lo[DATA_WIDTH-1:1]};
    end
  end

  // Restoring step; with B == 0 every compare succeeds, giving all-ones quotient and remainder == A.
  always_comb begin
    w_shift = {r_hi, r_lo[DATA_WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_b});
    if (w_ge) begin
      w_div_hi = w_shift[DATA_WIDTH-1:0] - r_b;
      w_div_lo = {r_lo[DATA_WIDTH-2:0], 1'b1};
    end else begin
      w_div_hi = w_shift[DATA_WIDTH-1:0];
      w_div_lo = {r_lo[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= MULDIV_MUL;
      r_b   <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op  <= muldiv_op_t'(in_op);
            r_b   <= in_b;
            r_rd  <= in_rd;
            r_cnt <= CNT_W'(DATA_WIDTH);
            r_hi  <= '0;
            r_lo  <= in_a;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_is_mul) begin
            r_hi <= w_mul_hi;
            r_lo <= w_mul_lo;
          end else begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);

  // Outputs are forced to zero outside DONE so an idle unit writes nothing useful.
  always_comb begin
    out_rd   = '0;
    out_data = '0;
    if (r_state == S_DONE) begin
      out_rd = r_rd;
      case (r_op)
        MULDIV_MUL:   out_data = r_lo;
        MULDIV_MULHU: out_data = r_hi;
        MULDIV_DIVU:  out_data = r_lo;
        MULDIV_REMU:  out_data = r_hi;
        default:      out_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: reference results queued at issue, compared at writeback.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_a, in_b;
  logic [4:0]    in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    out_rd;
  logic [W-1:0]  out_data;
  logic          busy;

  typedef struct {
    logic [4:0]   rd;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd);
    int wait_cnt = 0;
    while (!in_ready && wait_cnt < 100) begin
      tick();
      wait_cnt++;
    end
    check("ready_before_issue", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op = op; in_a = a; in_b = b; in_rd = rd;
    sb.push_back('{rd: rd, data: model(op, a, b)});
    tick();
    in_valid = 1'b0;
    in_op = 2'($urandom); in_a = $urandom; in_b = $urandom; in_rd = 5'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] rd, input int stall);
    int   lat;
    exp_t e;
    logic [4:0]   h_rd;
    logic [W-1:0] h_data;
    issue(op, a, b, rd);
    lat = 1;
    check({tag, "_busy"}, {62'd0, busy, in_ready}, 64'b10);
    check({tag, "_idle_out"}, {27'd0, out_rd, out_data}, 64'd0);
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd33);
    h_rd = out_rd;
    h_data = out_data;
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold"}, {25'd0, out_valid, in_ready, out_rd, out_data},
            {25'd0, 1'b1, 1'b0, h_rd, h_data});
    end
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_rd"}, 64'(out_rd), 64'(e.rd));
      check({tag, "_data"}, 64'(out_data), 64'(e.data));
    end
    tick();
    out_ready = 1'b0;
    check({tag, "_after"}, {25'd0, out_valid, in_ready, out_rd, out_data}, {25'd0, 2'b01, 37'd0});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_op = 2'd0; in_a = 32'd5; in_b = 32'd5; in_rd = 5'd1;
    out_ready = 1'b1;
    tick();
    tick();
    // reset wins over a simultaneous request
    check("reset_state", {25'd0, in_ready, out_valid, busy, out_rd, out_data},
          {25'd0, 3'b100, 37'd0});
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    tick();

    run_op("mul_7x6",       2'd0, 32'd7,          32'd6,          5'd5,  0);
    run_op("mulhu_ones",    2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  0);
    run_op("mul_ones",      2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  0);
    run_op("divu_100_7",    2'd2, 32'd100,        32'd7,          5'd8,  10);
    run_op("remu_100_7",    2'd3, 32'd100,        32'd7,          5'd9,  0);
    run_op("remu_big_1",    2'd3, 32'h8000_0000,  32'd1,          5'd10, 0);
    run_op("divu_9_0",      2'd2, 32'd9,          32'd0,          5'd11, 0);
    run_op("remu_9_0",      2'd3, 32'd9,          32'd0,          5'd12, 2);
    run_op("mulhu_mixed",   2'd1, 32'h1234_5678,  32'h9ABC_DEF0,  5'd13, 0);
    run_op("divu_mixed",    2'd2, 32'hDEAD_BEEF,  32'h0000_1234,  5'd0,  0);
    for (int k = 0; k < 4; k++)
      run_op("rand", 2'(k), $urandom, 32'($urandom_range(1, 65535)), 5'($urandom), 1);

    // abandon an operation part-way through CALC
    issue(2'd0, 32'd1000, 32'd1000, 5'd3);
    void'(sb.pop_back());
    repeat (11) tick();
    check("mid_calc_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", {61'd0, out_valid, busy, in_ready}, 64'b001);
    run_op("mul_3x3", 2'd0, 32'd3, 32'd3, 5'd4, 0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
